// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: loads big-endian 32-bit words from a byte stream into instruction memory
//   clk, reset          : clock and synchronous active-high reset
//   start, num_words    : begin a load of num_words words (sampled when IDLE/DONE)
//   in_byte, in_valid   : byte stream input; in_ready says a byte is taken this cycle
//   mem_we/addr/wdata   : one-cycle word write at BASE_ADDR + 4*word_idx
//   busy, cpu_hold      : load in progress / CPU stall request (identical)
//   done, error         : last load finished / last start had an illegal count
module instruction_memory_loader #(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [8:0]  num_words,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [8:0]  word_idx_q, word_idx_d, count_q, count_d;
   logic [23:0] acc_q, acc_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        error_q, error_d;
   logic        take_start, legal, xfer, last;
   assign take_start = start && (state_q == IDLE || state_q == DONE);
   assign legal      = num_words != 9'd0 && 32'(num_words) <= DEPTH;
   assign xfer       = state_q == RECV && in_valid;
   assign last       = word_idx_q == count_q - 9'd1;
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_idx_d = word_idx_q;
      count_d    = count_q;
      acc_d      = acc_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      error_d    = error_q;
      if (take_start) begin
         error_d = !legal;
         state_d = legal ? RECV : DONE;
         if (legal) begin
            count_d    = num_words;
            byte_cnt_d = 2'd0;
            word_idx_d = 9'd0;
            acc_d      = 24'd0;
         end
      end else if (xfer) begin
         // Shift left so the first byte of a word ends up in bits [31:24]
         acc_d      = {acc_q[15:0], in_byte};
         byte_cnt_d = byte_cnt_q + 2'd1;
         if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = BASE_ADDR + {21'd0, word_idx_q, 2'b00};
            wdata_d = {acc_q, in_byte};
         end
      end else if (state_q == WRITE) begin
         // Hold the index on the final word so it never passes DEPTH-1
         word_idx_d = last ? word_idx_q : word_idx_q + 9'd1;
         state_d    = last ? DONE : RECV;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         byte_cnt_q <= 2'd0;
         word_idx_q <= 9'd0;
         count_q    <= 9'd0;
         acc_q      <= 24'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_idx_q <= word_idx_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         error_q    <= error_d;
      end
   end
   assign in_ready  = state_q == RECV;
   assign mem_we    = state_q == WRITE;
   assign busy      = state_q == RECV || state_q == WRITE;
   assign cpu_hold  = busy;
   assign done      = state_q == DONE;
   assign error     = error_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// tb_instruction_memory_loader: directed self-checking bench for instruction_memory_loader
module tb_instruction_memory_loader;
   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [8:0]  num_words;
   logic [7:0]  in_byte;
   logic        in_ready, mem_we, busy, cpu_hold, done, error;
   logic [31:0] mem_addr, mem_wdata;
   int          n_chk = 0, n_fail = 0;
   logic [63:0] wq[$];
   instruction_memory_loader dut (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
   );
   always #5 clk = ~clk;
   // flags = {in_ready, mem_we, busy, cpu_hold, done, error}
   localparam logic [5:0] F_IDLE = 6'b000000, F_RECV = 6'b101100, F_WR = 6'b011100,
                          F_DONE = 6'b000010, F_ERR = 6'b000011;
   typedef struct {
      logic        rst, st, v;
      logic [8:0]  nw;
      logic [7:0]  b;
      logic [5:0]  flags;
      logic [31:0] addr, data;
   } vec_t;
   vec_t tv[$];
   function automatic vec_t mk(logic rst, logic st, logic [8:0] nw, logic v, logic [7:0] b,
                               logic [5:0] f, logic [31:0] a = 0, logic [31:0] d = 0);
      vec_t r;
      r.rst = rst; r.st = st; r.nw = nw; r.v = v; r.b = b; r.flags = f; r.addr = a; r.data = d;
      return r;
   endfunction
   function automatic logic [5:0] flags_now();
      return {in_ready, mem_we, busy, cpu_hold, done, error};
   endfunction
   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   always @(negedge clk) if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      check("write_side_flags", {62'd0, in_ready, cpu_hold}, 64'd1);
   end
   task automatic send(logic [7:0] b);
      bit ok = 0;
      in_valid = 1'b1;
      in_byte  = b;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            @(negedge clk);
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!ok) check("send_timeout", 64'd0, 64'd1);
   endtask
   task automatic do_start(logic [8:0] n);
      start = 1'b1;
      num_words = n;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("done_timeout", 64'd0, 64'd1);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; num_words = 9'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      // One-word load, illegal counts, a two-word load with a stray byte during WRITE, reset vs start
      tv.push_back(mk(0, 1, 9'd1, 0, 8'h00, F_IDLE));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h8C, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h01, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h00, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h04, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 0, 8'h00, F_WR, 32'h0, 32'h8C01_0004));
      tv.push_back(mk(0, 0, 9'd0, 0, 8'h00, F_DONE));
      tv.push_back(mk(0, 1, 9'd0, 0, 8'h00, F_DONE));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'hEE, F_ERR));
      tv.push_back(mk(0, 1, 9'd257, 0, 8'h00, F_ERR));
      tv.push_back(mk(0, 0, 9'd0, 0, 8'h00, F_ERR));
      tv.push_back(mk(0, 1, 9'd2, 1, 8'h55, F_ERR));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h11, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h22, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h33, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h44, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h99, F_WR, 32'h0, 32'h1122_3344));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'hA1, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'hB2, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'hC3, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'hD4, F_RECV));
      tv.push_back(mk(0, 0, 9'd0, 0, 8'h00, F_WR, 32'h4, 32'hA1B2_C3D4));
      tv.push_back(mk(0, 0, 9'd0, 0, 8'h00, F_DONE));
      tv.push_back(mk(1, 1, 9'd1, 0, 8'h00, F_DONE));
      tv.push_back(mk(0, 0, 9'd0, 0, 8'h00, F_IDLE));
      tv.push_back(mk(0, 0, 9'd0, 1, 8'h77, F_IDLE));
      foreach (tv[i]) begin
         reset = tv[i].rst; start = tv[i].st; num_words = tv[i].nw;
         in_valid = tv[i].v; in_byte = tv[i].b;
         #1;
         check($sformatf("vec%0d_flags", i), {58'd0, flags_now()}, {58'd0, tv[i].flags});
         if (tv[i].flags[4]) check($sformatf("vec%0d_write", i), {mem_addr, mem_wdata}, {tv[i].addr, tv[i].data});
         @(negedge clk);
      end
      reset = 1'b0; start = 1'b0; in_valid = 1'b0;
      // Three words with in_valid gaps between bytes
      do_reset();
      wq.delete();
      do_start(9'd3);
      check("hold_after_start", {63'd0, cpu_hold}, 64'd1);
      for (int k = 0; k < 12; k++) begin
         send(8'(8'hA0 + k));
         @(negedge clk);
      end
      wait_done();
      check("three_count", 64'(wq.size()), 64'd3);
      if (wq.size() == 3) begin
         check("three_w0", wq[0], {32'h0, 32'hA0A1_A2A3});
         check("three_w1", wq[1], {32'h4, 32'hA4A5_A6A7});
         check("three_w2", wq[2], {32'h8, 32'hA8A9_AAAB});
      end
      check("three_end_flags", {58'd0, flags_now()}, {58'd0, F_DONE});
      // Full depth, byte k of the stream is k mod 256
      wq.delete();
      do_start(9'd256);
      for (int k = 0; k < 1024; k++) send(8'(k));
      wait_done();
      check("full_count", 64'(wq.size()), 64'd256);
      begin
         int bad = 0;
         foreach (wq[i]) begin
            logic [7:0] b0;
            b0 = 8'(4 * i);
            if (wq[i] !== {32'(4 * i), b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}) bad++;
         end
         check("full_data_errors", 64'(bad), 64'd0);
      end
      if (wq.size() > 0) check("full_last_addr", {32'd0, wq[wq.size() - 1][63:32]}, 64'h3FC);
      check("full_end_flags", {58'd0, flags_now()}, {58'd0, F_DONE});
      // Reset after two bytes of the second word
      wq.delete();
      do_start(9'd2);
      for (int k = 0; k < 6; k++) send(8'(8'h10 + k));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_flags", {58'd0, flags_now()}, {58'd0, F_IDLE});
      repeat (5) @(negedge clk);
      check("rst_count", 64'(wq.size()), 64'd1);
      if (wq.size() == 1) check("rst_w0", wq[0], {32'h0, 32'h1011_1213});
      wq.delete();
      do_start(9'd1);
      for (int k = 0; k < 4; k++) send(8'(8'hC0 + k));
      wait_done();
      check("rst_reload_count", 64'(wq.size()), 64'd1);
      if (wq.size() == 1) check("rst_reload_w", wq[0], {32'h0, 32'hC0C1_C2C3});
      // Start pulse while busy is ignored
      wq.delete();
      do_start(9'd2);
      send(8'h01);
      send(8'h02);
      do_start(9'd5);
      for (int k = 3; k <= 8; k++) send(8'(k));
      wait_done();
      repeat (10) @(negedge clk);
      check("busy_start_count", 64'(wq.size()), 64'd2);
      if (wq.size() == 2) check("busy_start_w1", wq[1], {32'h4, 32'h0506_0708});
      check("busy_start_flags", {58'd0, flags_now()}, {58'd0, F_DONE});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
